// File: rtl/irsram_ctrl.sv
// irsram_ctrl: fills the irsram banks with a frame of rows, then drains them through a credit-limited output FIFO.
// Optional IRSRAM_CTRL_REVERSE_EN adds cfg_rev, which drains rows in reverse order.
`ifndef SRAM_NUM
`define SRAM_NUM 4
`endif

module irsram_ctrl_lane #(
  parameter int AW = 7,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic          en,
  input  logic [AW-1:0] a,
  input  logic [DW-1:0] d,
  output logic          wen,
  output logic [AW-1:0] a_q,
  output logic [DW-1:0] d_q
);
  always_ff @(posedge clk) begin
    if (rst) begin
      wen <= 1'b1;
      a_q <= '0;
      d_q <= '0;
    end else begin
      wen <= ~we;
      if (en) a_q <= a;
      if (we) d_q <= d;
    end
  end
endmodule

module irsram_ctrl #(
  parameter int SRAM_NUM    = `SRAM_NUM,
  parameter int AW          = 7,
  parameter int DW          = 16,
  parameter int OFIFO_DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [AW-1:0]          cfg_len,
`ifdef IRSRAM_CTRL_REVERSE_EN
  input  logic                   cfg_rev,
`endif
  output logic                   busy,
  output logic                   done,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [SRAM_NUM*DW-1:0] in_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [SRAM_NUM*DW-1:0] out_data,
  output logic                   sram_CEN,
  output logic [SRAM_NUM-1:0]    sram_WEN,
  output logic [SRAM_NUM*AW-1:0] sram_A,
  output logic [SRAM_NUM*DW-1:0] sram_D,
  input  logic [SRAM_NUM*DW-1:0] sram_Q
);
  localparam int RW     = SRAM_NUM*DW;
  localparam int CW     = AW+1;
  localparam int STAGES = 1;
  localparam int FPW    = (OFIFO_DEPTH > 1) ? $clog2(OFIFO_DEPTH) : 1;
  localparam int FCW    = $clog2(OFIFO_DEPTH+1) + 1;

  typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;
  state_t state_q, state_d;

  logic [CW-1:0]   len_q, wr_ptr, rd_cnt, out_cnt;
  logic [AW-1:0]   rd_idx, a_mux;
  logic [STAGES:0] vld_pipe;  // [0]: read on pins, [1]: sram_Q valid
  logic [RW-1:0]   fifo [OFIFO_DEPTH];
  logic [FPW-1:0]  f_wp, f_rp;
  logic [FCW-1:0]  fcnt, inflight;
  logic            wr_fire, rd_issue, push, pop, last_out, done_q, cen_q;

  function automatic logic [FPW-1:0] fnext(input logic [FPW-1:0] p);
    return (p == FPW'(OFIFO_DEPTH-1)) ? '0 : p + FPW'(1);
  endfunction

`ifdef IRSRAM_CTRL_REVERSE_EN
  logic rev_q;
  assign rd_idx = rev_q ? AW'(len_q - CW'(1) - rd_cnt) : rd_cnt[AW-1:0];
`else
  assign rd_idx = rd_cnt[AW-1:0];
`endif

  assign inflight  = FCW'(vld_pipe[0]) + FCW'(vld_pipe[1]);
  assign in_ready  = (state_q == FILL) && (wr_ptr < len_q);
  assign wr_fire   = in_valid & in_ready;
  // Credit covers FIFO occupancy plus reads still travelling through the bank.
  assign rd_issue  = (state_q == DRAIN) && (rd_cnt < len_q) &&
                     ((fcnt + inflight) < FCW'(OFIFO_DEPTH));
  assign push      = vld_pipe[STAGES];
  assign out_valid = (fcnt != '0);
  assign pop       = out_valid & out_ready;
  assign out_data  = out_valid ? fifo[f_rp] : '0;
  assign last_out  = pop && (out_cnt == len_q - CW'(1));
  assign busy      = (state_q != IDLE);
  assign done      = done_q;
  assign sram_CEN  = cen_q;
  assign a_mux     = wr_fire ? wr_ptr[AW-1:0] : rd_idx;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = FILL;
      FILL:    if (wr_fire && (wr_ptr == len_q - CW'(1))) state_d = DRAIN;
      DRAIN:   if (last_out) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      len_q    <= '0;
      wr_ptr   <= '0;
      rd_cnt   <= '0;
      out_cnt  <= '0;
      vld_pipe <= '0;
      f_wp     <= '0;
      f_rp     <= '0;
      fcnt     <= '0;
      done_q   <= 1'b0;
      cen_q    <= 1'b1;
`ifdef IRSRAM_CTRL_REVERSE_EN
      rev_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      done_q   <= last_out;
      cen_q    <= ~(wr_fire | rd_issue);
      vld_pipe <= {vld_pipe[STAGES-1:0], rd_issue};
      if (state_q == IDLE && start) begin
        len_q   <= (cfg_len == '0) ? CW'(2**AW) : {1'b0, cfg_len};
        wr_ptr  <= '0;
        rd_cnt  <= '0;
        out_cnt <= '0;
`ifdef IRSRAM_CTRL_REVERSE_EN
        rev_q   <= cfg_rev;
`endif
      end else begin
        if (wr_fire)  wr_ptr  <= wr_ptr + CW'(1);
        if (rd_issue) rd_cnt  <= rd_cnt + CW'(1);
        if (pop)      out_cnt <= out_cnt + CW'(1);
      end
      if (push) f_wp <= fnext(f_wp);
      if (pop)  f_rp <= fnext(f_rp);
      if (push && !pop)      fcnt <= fcnt + FCW'(1);
      else if (pop && !push) fcnt <= fcnt - FCW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo[f_wp] <= sram_Q;
  end

  for (genvar i = 0; i < SRAM_NUM; i++) begin : g_lane
    irsram_ctrl_lane #(.AW(AW), .DW(DW)) u_lane (
      .clk (clk),
      .rst (rst),
      .we  (wr_fire),
      .en  (wr_fire | rd_issue),
      .a   (a_mux),
      .d   (in_data[(i+1)*DW-1 -: DW]),
      .wen (sram_WEN[i]),
      .a_q (sram_A[(i+1)*AW-1 -: AW]),
      .d_q (sram_D[(i+1)*DW-1 -: DW])
    );
  end
endmodule

// File: tb/tb_irsram_ctrl.sv
// Testbench for irsram_ctrl: behavioural bank model, table of frames, and hand sequences for reset/latency corners.
module tb_irsram_ctrl;
  localparam int N  = 2;
  localparam int AW = 7;
  localparam int DW = 16;
  localparam int RW = N*DW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] cfg_len = '0;
`ifdef IRSRAM_CTRL_REVERSE_EN
  logic          cfg_rev = 1'b0;
`endif
  logic          busy, done, in_ready, out_valid, sram_CEN;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [RW-1:0] in_data = '0;
  logic [RW-1:0] out_data, sram_D, sram_Q;
  logic [N-1:0]  sram_WEN;
  logic [N*AW-1:0] sram_A;

  irsram_ctrl #(.SRAM_NUM(N), .AW(AW), .DW(DW), .OFIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_len(cfg_len),
`ifdef IRSRAM_CTRL_REVERSE_EN
    .cfg_rev(cfg_rev),
`endif
    .busy(busy), .done(done), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .sram_CEN(sram_CEN), .sram_WEN(sram_WEN), .sram_A(sram_A), .sram_D(sram_D), .sram_Q(sram_Q)
  );

  always #5 clk = ~clk;

  // Bank model: per-bank write enables, read data the cycle after the command.
  logic [RW-1:0] mem [128];
  always @(posedge clk) begin
    if (!sram_CEN) begin
      for (int b = 0; b < N; b++)
        if (!sram_WEN[b]) mem[sram_A[AW-1:0]][b*DW +: DW] <= sram_D[b*DW +: DW];
      if (&sram_WEN) sram_Q <= mem[sram_A[AW-1:0]];
    end
  end

  typedef struct {
    int len; int gap; int stall; bit bp; bit poke; int exp_rows;
  } vec_t;
  vec_t tbl [6];

  int checks = 0, fails = 0, cyc = 0;
  logic [RW-1:0]    dq [$];
  logic [AW+RW-1:0] wq [$];
  bit   hs_in, hs_out, prev_stall, rev_mode, seq_mode;
  int   done_cnt, reads, pops, wcount, ridx, first_rd, first_ov, dcyc, L, seqv, dur;
  logic [RW-1:0] prev_od;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", n, act, exp, cyc);
    end
  endtask

  task automatic newrow();
    if (seq_mode) begin
      seqv++;
      in_data = {N{seqv[15:0]}};
    end else
      for (int b = 0; b < N; b++) in_data[b*DW +: DW] = 16'($urandom);
  endtask

  task automatic mon();
    logic [AW+RW-1:0] we;
    logic [RW-1:0]    e;
    hs_in  = in_valid & in_ready;
    hs_out = out_valid & out_ready;
    if (hs_in) begin
      dq.push_back(in_data);
      wq.push_back({AW'(wcount), in_data});
      wcount++;
    end
    if (!sram_CEN) begin
      chk("wen_uniform", 64'((sram_WEN == '0) || (&sram_WEN)), 1);
      chk("addr_repl", 64'(sram_A[2*AW-1:AW]), 64'(sram_A[AW-1:0]));
    end
    if (!sram_CEN && sram_WEN == '0) begin
      if (wq.size() == 0) chk("write_unexpected", 1, 0);
      else begin
        we = wq.pop_front();
        chk("wr_addr", 64'(sram_A[AW-1:0]), 64'(we[RW +: AW]));
        chk("wr_data", 64'(sram_D), 64'(we[RW-1:0]));
      end
    end
    if (hs_out) begin
      pops++;
      if (dq.size() == 0) chk("out_unexpected", 1, 0);
      else begin
        e = rev_mode ? dq.pop_back() : dq.pop_front();
        chk("out_data", 64'(out_data), 64'(e));
      end
    end
    if (!sram_CEN && (&sram_WEN)) begin
      reads++;
      chk("rd_addr", 64'(sram_A[AW-1:0]), 64'(rev_mode ? L-1-ridx : ridx));
      ridx++;
      if (first_rd < 0) first_rd = cyc;
      chk("outstanding_le4", 64'((reads - pops) <= 4), 1);
    end
    if (prev_stall) begin
      chk("hold_valid", 64'(out_valid), 1);
      chk("hold_data", 64'(out_data), 64'(prev_od));
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
    if (done) begin
      done_cnt++;
      dcyc = cyc;
      chk("ov_after_last", 64'(out_valid), 0);
      chk("busy_at_done", 64'(busy), 0);
    end
    prev_stall = out_valid & ~out_ready;
    prev_od    = out_data;
  endtask

  task automatic step();
    @(negedge clk);
    mon();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_frame(input int len, input int gap, input int stall, input bit bp,
                           input bit poke, input bit rev, input int exp_rows);
    int k, s;
    L = (len == 0) ? 128 : len;
    rev_mode = rev;
    dq.delete(); wq.delete();
    wcount = 0; ridx = 0; reads = 0; pops = 0; done_cnt = 0;
    first_rd = -1; first_ov = -1; prev_stall = 0;
    start = 1'b1; cfg_len = AW'(len);
`ifdef IRSRAM_CTRL_REVERSE_EN
    cfg_rev = rev;
`endif
    in_valid = 1'b0; out_ready = 1'b0;
    newrow();
    s = cyc;
    step();
    start = 1'b0;
    chk("busy_after_start", 64'(busy), 1);
    k = 0;
    while (done_cnt == 0 && k < 3000) begin
      in_valid = ($urandom_range(99) >= gap);
      if (bp) out_ready = (first_ov < 0 || cyc - first_ov < 10) ? 1'b0 : 1'(cyc % 2);
      else    out_ready = ($urandom_range(99) >= stall);
      if (poke && k == 2) begin start = 1'b1; cfg_len = AW'(2); end
      else start = 1'b0;
      step();
      if (hs_in) newrow();
      k++;
    end
    start = 1'b0; in_valid = 1'b0;
    if (done_cnt == 0) chk("done_timeout", 0, 1);
    dur = dcyc - s;
    repeat (3) step();
    chk("done_once", 64'(done_cnt), 1);
    chk("rows_out", 64'(pops), 64'(exp_rows));
    chk("rows_in", 64'(wcount), 64'(exp_rows));
    chk("writes_left", 64'(wq.size()), 0);
    chk("sb_empty", 64'(dq.size()), 0);
  endtask

  initial begin
    tbl[0] = '{4,   0,  0,  1'b0, 1'b0, 4};
    tbl[1] = '{0,   30, 0,  1'b0, 1'b0, 128};
    tbl[2] = '{8,   0,  0,  1'b1, 1'b0, 8};
    tbl[3] = '{5,   0,  0,  1'b0, 1'b1, 5};
    tbl[4] = '{1,   0,  0,  1'b0, 1'b0, 1};
    tbl[5] = '{5,   50, 40, 1'b0, 1'b0, 5};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_cen", 64'(sram_CEN), 1);
    chk("rst_wen", 64'(sram_WEN), 64'({N{1'b1}}));
    chk("rst_a", 64'(sram_A), 0);
    chk("rst_d", 64'(sram_D), 0);
    chk("rst_in_ready", 64'(in_ready), 0);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_data", 64'(out_data), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_done", 64'(done), 0);
    @(posedge clk); #1;

    for (int i = 0; i < 6; i++) begin
      seq_mode = (i == 0);
      seqv = 0;
      run_frame(tbl[i].len, tbl[i].gap, tbl[i].stall, tbl[i].bp, tbl[i].poke, 1'b0, tbl[i].exp_rows);
      if (i == 0) begin
        chk("frame_cycles_le14", 64'(dur <= 14), 1);
        chk("first_out_latency", 64'(first_ov - first_rd), 2);
      end
    end

    // Reset in the middle of FILL, then a fresh frame from address 0.
    seq_mode = 0;
    rev_mode = 0;
    L = 6; wcount = 0; ridx = 0; reads = 0; pops = 0; first_ov = -1; first_rd = -1;
    start = 1'b1; cfg_len = AW'(6); newrow();
    step();
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      step();
      if (hs_in) newrow();
    end
    rst = 1'b1;
    step();
    @(negedge clk);
    chk("midrst_cen", 64'(sram_CEN), 1);
    chk("midrst_wen", 64'(sram_WEN), 64'({N{1'b1}}));
    chk("midrst_busy", 64'(busy), 0);
    chk("midrst_in_ready", 64'(in_ready), 0);
    chk("midrst_out_valid", 64'(out_valid), 0);
    @(posedge clk); #1;
    cyc++;
    rst = 1'b0; in_valid = 1'b0;
    step();
    seq_mode = 1; seqv = 100;
    run_frame(3, 0, 0, 1'b0, 1'b0, 1'b0, 3);

`ifdef IRSRAM_CTRL_REVERSE_EN
    seqv = 9;
    run_frame(3, 0, 0, 1'b0, 1'b0, 1'b1, 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
